// File: rtl/stack_ptr_unit.sv
// Word-aligned stack pointer with a valid/ready command port, bounds checking
// and a sticky error state that holds until err_clr.
module stack_ptr_unit #(
  parameter int            N           = 8,
  parameter logic [N-1:0]  STACK_BASE  = 8'hFC,
  parameter logic [N-1:0]  STACK_LIMIT = 8'h80
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] ld_val,
  output logic         cmd_ready,
  input  logic         err_clr,
  output logic [N-1:0] sp,
  output logic [N-1:0] mem_addr,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code
);

  typedef enum logic [1:0] {IDLE, EXEC, ERR} state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_OVF  = 2'b01;
  localparam logic [1:0] CODE_UDF  = 2'b10;
  localparam logic [1:0] CODE_BAD  = 2'b11;

  localparam logic [N-1:0] WORD      = N'(4);
  // Bounds held in N+1 bits so LIMIT+4 cannot wrap
  localparam logic [N:0]   PUSH_MIN  = {1'b0, STACK_LIMIT} + (N+1)'(4);
  localparam logic [N:0]   POP_MAX   = {1'b0, STACK_BASE} - (N+1)'(4);

  state_t       state_reg;
  logic [1:0]   op_reg;
  logic [N-1:0] ld_val_reg;
  logic [N-1:0] sp_reg;
  logic [N-1:0] mem_addr_reg;
  logic         done_reg;
  logic         err_reg;
  logic [1:0]   err_code_reg;

  logic [N-1:0] dec_sp;
  logic [N-1:0] inc_sp;
  logic [N-3:0] borrow;
  logic         push_ovf;
  logic         pop_udf;
  logic         load_bad;

  // DEC stage: word-granular ripple-borrow decrement of sp[N-1:2]
  assign dec_sp[1:0] = sp_reg[1:0];
  assign borrow[0]   = 1'b1;

  generate
    for (genvar gi = 1; gi < N - 2; gi++) begin : g_borrow
      assign borrow[gi] = borrow[gi-1] & ~sp_reg[gi+1];
    end
    for (genvar gi = 0; gi < N - 2; gi++) begin : g_dec
      assign dec_sp[gi+2] = sp_reg[gi+2] ^ borrow[gi];
    end
  endgenerate

  assign inc_sp   = sp_reg + WORD;
  assign push_ovf = {1'b0, sp_reg} < PUSH_MIN;
  assign pop_udf  = {1'b0, sp_reg} > POP_MAX;
  assign load_bad = (|ld_val_reg[1:0]) || (ld_val_reg < STACK_LIMIT) ||
                    (ld_val_reg > STACK_BASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= 2'b11;
      ld_val_reg   <= '0;
      sp_reg       <= STACK_BASE;
      mem_addr_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= CODE_NONE;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            op_reg     <= cmd_op;
            ld_val_reg <= ld_val;
            state_reg  <= EXEC;
          end
        end
        EXEC: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
          case (op_reg)
            OP_PUSH: begin
              if (push_ovf) begin
                err_reg      <= 1'b1;
                err_code_reg <= CODE_OVF;
                mem_addr_reg <= sp_reg;
                state_reg    <= ERR;
              end else begin
                sp_reg       <= dec_sp;
                mem_addr_reg <= dec_sp;
              end
            end
            OP_POP: begin
              mem_addr_reg <= sp_reg;
              if (pop_udf) begin
                err_reg      <= 1'b1;
                err_code_reg <= CODE_UDF;
                state_reg    <= ERR;
              end else begin
                sp_reg <= inc_sp;
              end
            end
            OP_LOAD: begin
              if (load_bad) begin
                err_reg      <= 1'b1;
                err_code_reg <= CODE_BAD;
                state_reg    <= ERR;
              end else begin
                sp_reg       <= ld_val_reg;
                mem_addr_reg <= ld_val_reg;
              end
            end
            default: mem_addr_reg <= sp_reg;
          endcase
        end
        ERR: begin
          if (err_clr) begin
            err_reg      <= 1'b0;
            err_code_reg <= CODE_NONE;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_reg == IDLE) && rst_n;
  assign sp        = sp_reg;
  assign mem_addr  = mem_addr_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Scoreboard bench for stack_ptr_unit: driver predicts with an integer model,
// monitor pops and compares on every done pulse.
module tb_stack_ptr_unit;

  localparam int BASE  = 'hFC;
  localparam int LIMIT = 'h80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b11;
  logic [7:0] ld_val = 8'h00;
  logic       cmd_ready;
  logic       err_clr = 1'b0;
  logic [7:0] sp;
  logic [7:0] mem_addr;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  stack_ptr_unit dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .ld_val(ld_val), .cmd_ready(cmd_ready), .err_clr(err_clr), .sp(sp),
    .mem_addr(mem_addr), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  sp;
    int  addr;
    bit  chk_addr;
    int  err;
    int  code;
    int  op;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   m_sp = BASE;   // reference SP as a plain integer
  bit   m_err = 0;
  bit   prev_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: apply the command rules to the integer SP
  task automatic predict(input int op, input int val);
    exp_t e;
    e.op = op; e.chk_addr = 1; e.err = 0; e.code = 0;
    case (op)
      0: begin
        if (m_sp - 4 < LIMIT) begin e.err = 1; e.code = 1; e.addr = m_sp; end
        else begin m_sp = m_sp - 4; e.addr = m_sp; end
      end
      1: begin
        if (m_sp + 4 > BASE) begin e.err = 1; e.code = 2; e.addr = m_sp; end
        else begin e.addr = m_sp; m_sp = m_sp + 4; end
      end
      2: begin
        if ((val % 4) != 0 || val < LIMIT || val > BASE) begin
          e.err = 1; e.code = 3; e.chk_addr = 0; e.addr = 0;
        end else begin m_sp = val; e.addr = val; end
      end
      default: e.addr = m_sp;
    endcase
    e.sp = m_sp;
    m_err = e.err[0];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn op=%0d sp=%02h addr=%02h err=%0d code=%0d", e.op, sp, mem_addr, err, err_code);
        chk("sp", {24'b0, sp}, e.sp);
        chk("err", {31'b0, err}, e.err);
        chk("err_code", {30'b0, err_code}, e.code);
        if (e.chk_addr) chk("mem_addr", {24'b0, mem_addr}, e.addr);
      end
    end
    prev_done = rst_n && done;
  end

  task automatic issue(input int op, input int val);
    int waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op[1:0]; ld_val = val[7:0];
    while (!cmd_ready && waited < 20) begin @(negedge clk); waited++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      cmd_valid = 1'b0;
      return;
    end
    predict(op, val);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    chk("err_state_ready", {31'b0, cmd_ready}, 32'd0);
    chk("err_state_err", {31'b0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_err", {31'b0, err}, 32'd0);
    chk("clr_code", {30'b0, err_code}, 32'd0);
    chk("clr_ready", {31'b0, cmd_ready}, 32'd1);
    chk("clr_sp_kept", {24'b0, sp}, m_sp);
    m_err = 0;
  endtask

  task automatic do_op(input int op, input int val);
    issue(op, val);
    if (m_err) clear_err();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #1;
    chk("ready_in_reset", {31'b0, cmd_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_sp", {24'b0, sp}, BASE);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_addr", {24'b0, mem_addr}, 32'd0);

    // Push then pop around the empty position
    do_op(0, 0);
    do_op(1, 0);
    @(negedge clk);
    chk("push_pop_sp", {24'b0, sp}, 32'hFC);

    // Underflow; a held push must not be accepted while in error
    issue(1, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("held_off_ready", {31'b0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    clear_err();

    // Full-stack boundary
    do_op(2, 'h84);
    do_op(0, 0);
    do_op(0, 0);
    do_op(1, 0);
    @(negedge clk);
    chk("full_then_pop_sp", {24'b0, sp}, 32'h84);

    // Bad loads then a good one
    do_op(2, 'h83);
    do_op(2, 'h40);
    do_op(2, 'hFC);
    do_op(3, 0);

    // Reset during EXEC aborts the command
    do_op(2, 'hA0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    chk("pre_abort_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_sp", {24'b0, sp}, BASE);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_ready", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("abort_no_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    m_sp = BASE; m_err = 0;
    @(negedge clk);
    chk("abort_ready_after", {31'b0, cmd_ready}, 32'd1);
    chk("abort_done_after", {31'b0, done}, 32'd0);

    // Random walk
    for (int i = 0; i < 300; i++) begin
      int r;
      int v;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 3) != 0) v = LIMIT + 4 * $urandom_range(0, 31);
      else v = $urandom_range(0, 255);
      if (r <= 3)      do_op(0, 0);
      else if (r <= 6) do_op(1, 0);
      else if (r <= 8) do_op(2, v);
      else             do_op(3, 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
